// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_if
//  Description : Bundle for the register-file write-back arbiter. It carries
//                the two producer request channels, the register-file write
//                port, the branch-redirect output and the pending flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  // Requester 0: ALU write-back
  logic                  req0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] data0;
  logic                  rdy0;
  // Requester 1: load/memory write-back
  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] data1;
  logic                  rdy1;
  // Register-file write port
  logic [ADDR_WIDTH-1:0] rw;
  logic [DATA_WIDTH-1:0] pw;
  logic                  le;
  // Branch redirect for writes to R15
  logic                  br_valid;
  logic [DATA_WIDTH-1:0] br_target;
  // Holding-buffer occupancy {full1, full0}
  logic [1:0]            pending;

  // Arbiter side
  modport slave (
    input  req0, addr0, data0, req1, addr1, data1,
    output rdy0, rdy1, rw, pw, le, br_valid, br_target, pending
  );

  // Producer / register-file side
  modport master (
    output req0, addr0, data0, req1, addr1, data1,
    input  rdy0, rdy1, rw, pw, le, br_valid, br_target, pending
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Round-robin arbiter for the register file's single write
//                port. Each of the two producers owns a one-entry holding
//                buffer; granted writes drive registered RW/PW/LE, except
//                writes to R15, which become a one-cycle branch redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  regfile_wb_arbiter_if.slave  bus
);

  // Highest register address is the PC.
  localparam logic [ADDR_WIDTH-1:0] c_r15 = '1;

  // Holding buffers
  logic                  r_full0;
  logic [ADDR_WIDTH-1:0] r_addr0_q;
  logic [DATA_WIDTH-1:0] r_data0_q;
  logic                  r_full1;
  logic [ADDR_WIDTH-1:0] r_addr1_q;
  logic [DATA_WIDTH-1:0] r_data1_q;

  // Index of the most recently granted requester
  logic                  r_last;

  // Output registers
  logic [ADDR_WIDTH-1:0] r_rw;
  logic [DATA_WIDTH-1:0] r_pw;
  logic                  r_le;
  logic                  r_br_valid;
  logic [DATA_WIDTH-1:0] r_br_target;

  // Combinational arbitration
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_xfer0;
  logic                  w_xfer1;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_gnt_r15;

  // Grant depends only on buffer occupancy and the last winner, so RDY never
  // loops back through REQ. On contention the side that did not win last time
  // is served; r_last resets to 1 so requester 0 wins the first contention.
  always_comb begin
    w_gnt0 = r_full0 & (~r_full1 | r_last);
    w_gnt1 = r_full1 & (~r_full0 | ~r_last);
  end

  // A buffer can accept when empty or when it drains on this same edge.
  always_comb begin
    bus.rdy0 = ~r_full0 | w_gnt0;
    bus.rdy1 = ~r_full1 | w_gnt1;
    w_xfer0  = bus.req0 & bus.rdy0;
    w_xfer1  = bus.req1 & bus.rdy1;
  end

  // Select the granted buffer's contents and detect a PC write.
  always_comb begin
    w_gnt_addr = w_gnt1 ? r_addr1_q : r_addr0_q;
    w_gnt_data = w_gnt1 ? r_data1_q : r_data0_q;
    w_gnt_r15  = (w_gnt0 | w_gnt1) & (w_gnt_addr == c_r15);
  end

  // Requester 0 buffer: a refill on the grant edge wins over the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full0   <= 1'b0;
      r_addr0_q <= '0;
      r_data0_q <= '0;
    end else if (w_xfer0) begin
      r_full0   <= 1'b1;
      r_addr0_q <= bus.addr0;
      r_data0_q <= bus.data0;
    end else if (w_gnt0) begin
      r_full0   <= 1'b0;
    end
  end

  // Requester 1 buffer: a refill on the grant edge wins over the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full1   <= 1'b0;
      r_addr1_q <= '0;
      r_data1_q <= '0;
    end else if (w_xfer1) begin
      r_full1   <= 1'b1;
      r_addr1_q <= bus.addr1;
      r_data1_q <= bus.data1;
    end else if (w_gnt1) begin
      r_full1   <= 1'b0;
    end
  end

  // Remember the winner of every grant for the round-robin tie-break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_gnt0 | w_gnt1) begin
      r_last <= w_gnt1;
    end
  end

  // Drive the write port or the branch redirect; pulses last one cycle and
  // data fields hold their last value when not refreshed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw        <= '0;
      r_pw        <= '0;
      r_le        <= 1'b0;
      r_br_valid  <= 1'b0;
      r_br_target <= '0;
    end else begin
      r_le       <= 1'b0;
      r_br_valid <= 1'b0;
      if (w_gnt_r15) begin
        r_br_valid  <= 1'b1;
        r_br_target <= w_gnt_data;
      end else if (w_gnt0 | w_gnt1) begin
        r_le <= 1'b1;
        r_rw <= w_gnt_addr;
        r_pw <= w_gnt_data;
      end
    end
  end

  // Registered outputs onto the bus.
  always_comb begin
    bus.rw        = r_rw;
    bus.pw        = r_pw;
    bus.le        = r_le;
    bus.br_valid  = r_br_valid;
    bus.br_target = r_br_target;
    bus.pending   = {r_full1, r_full0};
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Self-checking bench for regfile_wb_arbiter. Directed steps
//                followed by a random phase, all compared cycle by cycle
//                against a queue-based model of the write-back rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst;

  regfile_wb_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  regfile_wb_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  // Model: each requester holds at most one queued write.
  wr_t         q0[$];
  wr_t         q1[$];
  logic        m_last;
  logic        m_le;
  logic        m_brv;
  logic [3:0]  m_rw;
  logic [31:0] m_pw;
  logic [31:0] m_brt;

  // Register file rebuilt from what the DUT actually commits.
  logic [31:0] dut_rf [16];

  int nchk  = 0;
  int npass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_last = 1'b1;
    m_le   = 1'b0;
    m_brv  = 1'b0;
    m_rw   = '0;
    m_pw   = '0;
    m_brt  = '0;
  endtask

  // One clock cycle: drive inputs, check RDY, advance the model at the edge,
  // then check the registered outputs half a cycle later.
  task automatic tick(input logic r0, input logic [3:0] a0, input logic [31:0] d0,
                      input logic r1, input logic [3:0] a1, input logic [31:0] d1);
    int   g;
    logic e_rdy0;
    logic e_rdy1;
    wr_t  it;
    bus.req0  = r0;
    bus.addr0 = a0;
    bus.data0 = d0;
    bus.req1  = r1;
    bus.addr1 = a1;
    bus.data1 = d1;
    #1;
    if (q0.size() > 0 && q1.size() > 0) g = (m_last == 1'b1) ? 0 : 1;
    else if (q0.size() > 0)             g = 0;
    else if (q1.size() > 0)             g = 1;
    else                                g = -1;
    e_rdy0 = (q0.size() == 0) || (g == 0);
    e_rdy1 = (q1.size() == 0) || (g == 1);
    chk("rdy0", bus.rdy0, e_rdy0);
    chk("rdy1", bus.rdy1, e_rdy1);
    if (bus.le === 1'b1) dut_rf[bus.rw] = bus.pw;
    @(posedge clk);
    m_le  = 1'b0;
    m_brv = 1'b0;
    if (g >= 0) begin
      if (g == 0) it = q0.pop_front();
      else        it = q1.pop_front();
      m_last = (g == 1);
      if (it.a == 4'hF) begin
        m_brv = 1'b1;
        m_brt = it.d;
      end else begin
        m_le = 1'b1;
        m_rw = it.a;
        m_pw = it.d;
      end
    end
    if (r0 && e_rdy0) begin
      it.a = a0; it.d = d0; q0.push_back(it);
    end
    if (r1 && e_rdy1) begin
      it.a = a1; it.d = d1; q1.push_back(it);
    end
    @(negedge clk);
    chk("le",        bus.le,        m_le);
    chk("br_valid",  bus.br_valid,  m_brv);
    chk("rw",        bus.rw,        m_rw);
    chk("pw",        bus.pw,        m_pw);
    chk("br_target", bus.br_target, m_brt);
    chk("pending",   bus.pending,   {q1.size() != 0, q0.size() != 0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dut_rf[i] = '0;
    model_reset();
    rst       = 1'b1;
    bus.req0  = 1'b0;
    bus.addr0 = '0;
    bus.data0 = '0;
    bus.req1  = 1'b0;
    bus.addr1 = '0;
    bus.data1 = '0;

    // Reset values and RDY while in reset
    #2;
    chk("rst_le",      bus.le,        1'b0);
    chk("rst_brv",     bus.br_valid,  1'b0);
    chk("rst_pending", bus.pending,   2'b00);
    chk("rst_rw",      bus.rw,        4'h0);
    chk("rst_pw",      bus.pw,        32'h0);
    chk("rst_brt",     bus.br_target, 32'h0);
    chk("rst_rdy0",    bus.rdy0,      1'b1);
    chk("rst_rdy1",    bus.rdy1,      1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_rdy0", bus.rdy0, 1'b1);
    chk("rel_rdy1", bus.rdy1, 1'b1);

    // Single write: R3 <= 20, LE for one cycle only
    tick(1'b1, 4'd3, 32'd20, 1'b0, 4'h0, 32'h0);
    idle(3);

    // Stream of 8 writes from requester 0
    for (int i = 0; i < 8; i++) tick(1'b1, 4'(i), 32'(20 + i), 1'b0, 4'h0, 32'h0);
    idle(2);

    // Continuous contention: alternation starting with the last loser
    for (int i = 0; i < 8; i++) tick(1'b1, 4'd1, 32'd100, 1'b1, 4'd2, 32'd200);
    idle(3);

    // R15 write diverted to the branch redirect
    tick(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h40);
    idle(3);

    // Same-address race after requester 0 was last granted
    tick(1'b1, 4'd2, 32'd1, 1'b0, 4'h0, 32'h0);
    idle(2);
    tick(1'b1, 4'd5, 32'd7, 1'b1, 4'd5, 32'd9);
    idle(4);
    chk("r5_final", dut_rf[5], 32'd7);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      tick(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom());
    end
    idle(3);

    // Mid-cycle reset with a full buffer and an LE pulse in flight
    tick(1'b1, 4'd6, 32'd60, 1'b0, 4'h0, 32'h0);
    tick(1'b1, 4'd7, 32'd70, 1'b0, 4'h0, 32'h0);
    bus.req0 = 1'b0;
    rst      = 1'b1;
    #1;
    chk("mrst_pending", bus.pending,  2'b00);
    chk("mrst_le",      bus.le,       1'b0);
    chk("mrst_brv",     bus.br_valid, 1'b0);
    chk("mrst_rdy0",    bus.rdy0,     1'b1);
    chk("mrst_rdy1",    bus.rdy1,     1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(3);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire
